// File: rtl/uart_sched_pkg.sv
// Shared types and width helpers for the UART word scheduler: FSM state
// encoding, index/counter width functions and the default word length.
package uart_sched_pkg;

    localparam int DEFAULT_BYTES_PER_WORD = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int CH_IDX_W(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

    // Width of the byte counter; holds 0 .. bytes_per_word-1.
    function automatic int BYTE_CNT_W(input int bytes_per_word);
        return (bytes_per_word > 2) ? $clog2(bytes_per_word) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req at or after ptr wins,
// wrapping modulo NUM_CH. Returns a one-hot grant and the winner's index.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // NOTE: every variable gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_word_scheduler.sv
// Shares one byte-serial UART link between NUM_CH word producers.
// Optional WAIT-state watchdog: define UART_WORD_SCHED_WATCHDOG_EN.
module uart_word_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int WORD_W         = 40,
    parameter int BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT        = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH*WORD_W-1:0]    data_in,
    output logic [NUM_CH-1:0]           ack,
    output logic [WORD_W-1:0]           data_out,
    output logic                        uart_start,
    input  logic                        uart_done,
    output logic [CH_IDX_W(NUM_CH)-1:0] grant_id,
    output logic                        busy,
    output logic                        error
);

    localparam int CH_W     = CH_IDX_W(NUM_CH);
    localparam int CNT_W    = BYTE_CNT_W(BYTES_PER_WORD);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    if (WORD_W != 8 * BYTES_PER_WORD) begin : g_bad_word_w
        $error("uart_word_scheduler: WORD_W must equal 8*BYTES_PER_WORD");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_word_scheduler: TIMEOUT must be at least 1");
    end

    state_t              state;
    logic [NUM_CH-1:0]   req_q;
    logic [CH_W-1:0]     rr_ptr;
    logic [NUM_CH-1:0]   grant_oh_q;
    logic [CNT_W-1:0]    byte_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [NUM_CH-1:0]   arb_grant;
    logic [CH_W-1:0]     arb_idx;
    logic [WORD_W-1:0]   words [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_words
        assign words[i] = data_in[i*WORD_W +: WORD_W];
    end

    // Arbitrates on the request snapshot taken in IDLE, not the live req.
    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_arb (
        .req       (req_q),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

`ifdef UART_WORD_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd_cnt;
`else
    assign error = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            rr_ptr     <= '0;
            grant_oh_q <= '0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            ack        <= '0;
            data_out   <= '0;
            uart_start <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
`ifdef UART_WORD_SCHED_WATCHDOG_EN
            wd_cnt     <= '0;
            error      <= 1'b0;
`endif
        end else begin
            ack        <= '0;
            uart_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        req_q <= req;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    data_out   <= words[arb_idx];
                    grant_id   <= arb_idx;
                    grant_oh_q <= arb_grant;
                    busy       <= 1'b1;
                    rr_ptr     <= (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
                    uart_start <= 1'b1;
                    state      <= ST_START;
                end
                ST_START: begin
`ifdef UART_WORD_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (uart_done) begin
                        if (byte_cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
                            byte_cnt <= '0;
                            ack      <= grant_oh_q;
                            busy     <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                uart_start <= 1'b1;
                                state      <= ST_START;
                            end else begin
                                gap_cnt <= GAP_W'(GAP_LOAD);
                                state   <= ST_GAP;
                            end
                        end
                    end
`ifdef UART_WORD_SCHED_WATCHDOG_EN
                    else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        // Abandon the word; rr_ptr already moved past this channel.
                        error    <= 1'b1;
                        byte_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        uart_start <= 1'b1;
                        state      <= ST_START;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_scheduler.sv
// Directed self-checking bench for uart_word_scheduler (4 channels, 5-byte
// words, 2-cycle gap). Watchdog cases run when UART_WORD_SCHED_WATCHDOG_EN is set.
module tb_uart_word_scheduler;

    localparam int NUM_CH = 4;
    localparam int WORD_W = 40;
    localparam int BPW    = 5;
    localparam int GAP    = 2;

    localparam logic [WORD_W-1:0] W0     = 40'h1122334455;
    localparam logic [WORD_W-1:0] W0_NEW = 40'h123456789a;
    localparam logic [WORD_W-1:0] W1     = 40'ha1a2a3a4a5;
    localparam logic [WORD_W-1:0] W2     = 40'hb1b2b3b4b5;
    localparam logic [WORD_W-1:0] W3     = 40'hc1c2c3c4c5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*WORD_W-1:0] data_in;
    logic [NUM_CH-1:0]        ack;
    logic [WORD_W-1:0]        data_out;
    logic                     uart_start;
    logic                     uart_done;
    logic [1:0]               grant_id;
    logic                     busy;
    logic                     error;

    int n_checks  = 0;
    int n_errors  = 0;
    int start_cnt = 0;
    int ack_cnt [NUM_CH] = '{default: 0};

    uart_word_scheduler #(
        .NUM_CH         (NUM_CH),
        .WORD_W         (WORD_W),
        .BYTES_PER_WORD (BPW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .data_out   (data_out),
        .uart_start (uart_start),
        .uart_done  (uart_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uart_start) start_cnt++;
        for (int i = 0; i < NUM_CH; i++) if (ack[i]) ack_cnt[i]++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for uart_start; returns the number of cycles waited.
    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!uart_start && cyc < 50) begin
            tick();
            cyc++;
        end
        check("start_seen", uart_start, 1);
    endtask

    // UART model: done pulse three cycles after the start pulse.
    task automatic byte_resp();
        repeat (3) tick();
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
    endtask

    // mode 0: keep req; 1: release all req on ack; 2: drop own req after first start.
    task automatic run_word(input int ch, input logic [WORD_W-1:0] word, input int mode,
                            input bit poke, input bit spurious);
        int cyc;
        int s0;
        s0 = start_cnt;
        wait_start(cyc);
        check("first_start_latency", cyc, 2);
        check("grant_id", grant_id, ch);
        check("data_out_grant", data_out, word);
        check("busy_start", busy, 1);
        if (poke) data_in[WORD_W-1:0] = W0_NEW;
        if (mode == 2) req[ch] = 1'b0;
        for (int b = 0; b < BPW; b++) begin
            if (b > 0) begin
                wait_start(cyc);
                check("gap_to_start", cyc, (spurious && b == 1) ? 1 : GAP);
                check("data_out_hold", data_out, word);
            end
            byte_resp();
            if (spurious && b == 0) begin
                uart_done = 1'b1;
                tick();
                uart_done = 1'b0;
            end
        end
        check("ack_after_last_done", ack, 64'(1) << ch);
        check("busy_at_ack", busy, 0);
        check("start_pulses", start_cnt - s0, BPW);
        if (mode == 1) req = '0;
        tick();
        check("ack_single_pulse", ack, 0);
    endtask

    initial begin
        int cyc;
        int acks_before;
        rst       = 1'b1;
        req       = '0;
        uart_done = 1'b0;
        data_in   = {W3, W2, W1, W0};
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_data_out", data_out, 0);
        check("rst_uart_start", uart_start, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        rst = 1'b0;
        tick();

        // Single request; granted channel drops req mid-word, ack still pulses.
        req = 4'b0001;
        run_word(0, W0, 2, 1'b0, 1'b0);
        tick();
        check("idle_busy", busy, 0);
        check("idle_no_start", uart_start, 0);
        check("ack_count_ch0", ack_cnt[0], 1);

        // Round robin from a fresh pointer; ch0 word changed after its grant,
        // spurious done injected in the gap during ch2's word.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        run_word(0, W0, 0, 1'b1, 1'b0);
        run_word(1, W1, 0, 1'b0, 1'b0);
        run_word(2, W2, 0, 1'b0, 1'b1);
        run_word(3, W3, 0, 1'b0, 1'b0);
        run_word(0, W0_NEW, 1, 1'b0, 1'b0);
        check("rr_ack_count_ch0", ack_cnt[0], 3);
        check("rr_ack_count_ch1", ack_cnt[1], 1);
        check("rr_ack_count_ch2", ack_cnt[2], 1);
        check("rr_ack_count_ch3", ack_cnt[3], 1);

        // Reset after the second done of ch1's word.
        req = 4'b0010;
        wait_start(cyc);
        byte_resp();
        wait_start(cyc);
        byte_resp();
        check("mid_word_data_out", data_out, W1);
        acks_before = ack_cnt[1];
        rst = 1'b1;
        tick();
        check("midrst_ack", ack, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_uart_start", uart_start, 0);
        check("midrst_grant_id", grant_id, 0);
        check("midrst_busy", busy, 0);
        check("midrst_error", error, 0);
        rst = 1'b0;
        check("midrst_no_ack", ack_cnt[1], acks_before);
        run_word(1, W1, 1, 1'b0, 1'b0);
        check("regrant_ack_count_ch1", ack_cnt[1], acks_before + 1);

`ifdef UART_WORD_SCHED_WATCHDOG_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0101;
        acks_before = ack_cnt[0];
        wait_start(cyc);
        check("wd_grant_id", grant_id, 0);
        repeat (16) tick();
        check("wd_error_before", error, 0);
        tick();
        check("wd_error_set", error, 1);
        check("wd_busy", busy, 0);
        check("wd_ack", ack, 0);
        req[0] = 1'b0;
        run_word(2, W2, 1, 1'b0, 1'b0);
        check("wd_no_ack_ch0", ack_cnt[0], acks_before);
        check("wd_error_sticky", error, 1);
`else
        check("error_tied_low", error, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_word_scheduler.md
Name: uart_word_scheduler

Overview:
- Shares the single byte-serial link (DataSender + UART transmitter) between NUM_CH sample producers.
- Round-robin arbitration picks one producer, latches its 40-bit word and holds it on the sender's dataIn until the word is finished.
- Paces the UART: one start pulse per byte, then waits for the matching done pulse, with a programmable inter-byte gap.
- Acknowledges the producer once all BYTES_PER_WORD bytes are done.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- WORD_W, 40, word width; must equal 8*BYTES_PER_WORD
- BYTES_PER_WORD, 5, bytes per word, LSB byte first (sequencing of bytes is done by DataSender)
- GAP_CYCLES, 2, idle cycles between a done pulse and the next start pulse (0 allowed)
- TIMEOUT, 1024, cycles to wait for uart_done (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req  in  NUM_CH  per-channel request; level, held until ack
- data_in  in  NUM_CH*WORD_W  channel words; channel i at bits [i*WORD_W +: WORD_W]
- ack  out  NUM_CH  one-cycle pulse to the granted channel when its word is complete
- data_out  out  WORD_W  latched word, drives DataSender dataIn
- uart_start  out  1  one-cycle pulse requesting transmission of the next byte
- uart_done  in  1  one-cycle pulse from the UART when a byte is complete
- grant_id  out  clog2(NUM_CH)  channel currently being sent
- busy  out  1  high from grant until ack
- error  out  1  sticky timeout flag (only with the optional feature; otherwise tied 0)

Behaviour:
- Reset values: ack=0, data_out=0, uart_start=0, grant_id=0, busy=0, error=0.
- Reset state: FSM in IDLE, byte_cnt=0, gap_cnt=0, rr_ptr=0 (channel 0 has top priority).
- Reset mid-word: abort immediately, no ack is issued, and the channel keeps its req.
- States: IDLE, GRANT, START, WAIT, GAP, DONE.
- IDLE: if any req bit is set, go to GRANT.
- GRANT (1 cycle):
  - Winner is the first set req at or after rr_ptr, wrapping modulo NUM_CH.
  - Latch data_out <= winner's word, set grant_id, busy=1, rr_ptr <= winner+1 (wraps).
  - Go to START.
- START (1 cycle): uart_start=1; go to WAIT.
- WAIT: on uart_done, byte_cnt++.
  - If byte_cnt was BYTES_PER_WORD-1, go to DONE.
  - Otherwise, if GAP_CYCLES=0, go to START; else load gap_cnt and go to GAP.
- GAP: count GAP_CYCLES cycles, then go to START.
- DONE (1 cycle): ack[grant_id]=1, busy=0, byte_cnt=0; go to IDLE.
- Latency: req rising in IDLE gives uart_start exactly 2 cycles later.
- Ack timing: ack follows the last uart_done by 1 cycle.
- A channel that holds req high after ack is re-arbitrated; it wins again only if no other channel requests.
- uart_done outside WAIT is ignored; byte_cnt is unchanged.
- data_out is stable from GRANT through DONE. Changes on data_in or req during this window have no effect.
- req dropped by a non-granted channel before it wins is never acked.
- req dropped by the granted channel mid-word: the word still completes and ack still pulses.
- Only the registered req sampled in IDLE/GRANT is used for arbitration.

Optional Feature:
- Macro: UART_WORD_SCHED_WATCHDOG_EN.
- When defined, a WAIT-state cycle counter runs. If it reaches TIMEOUT without uart_done:
  - set error (sticky until rst);
  - abort the word: no ack; byte_cnt=0, busy=0;
  - return to IDLE with rr_ptr already advanced.
- The counter clears on every entry to WAIT.
- When not defined: no counter is built, WAIT waits indefinitely, and error is constant 0.

Decomposition:
- Shared package uart_sched_pkg holds:
  - the state enum;
  - the CH_IDX_W and BYTE_CNT_W width functions (clog2);
  - the default BYTES_PER_WORD.
- One sub-module, rr_arbiter (inputs: req, ptr; output: one-hot grant plus index), purely combinational.
- Counters and the FSM stay in uart_word_scheduler.

Test Plan:
- Single request: req=4'b0001, data_in ch0='h1122334455; bench returns uart_done 3 cycles after each uart_start.
  -> data_out='h1122334455, exactly 5 uart_start pulses, ack=4'b0001 one cycle after the 5th done, busy low afterwards.
- Round-robin fairness: req=4'b1111 held continuously.
  -> grant_id sequence 0,1,2,3,0; each ack pulses once per word; data_out matches the granted channel each time.
- Data stability: change ch0 word to 'h123456789a after GRANT.
  -> data_out stays 'h1122334455 until DONE; the next grant of ch0 latches 'h123456789a.
- Gap and spurious done: GAP_CYCLES=2, extra uart_done pulse injected in GAP.
  -> it is ignored; byte_cnt is unchanged; the next uart_start comes exactly 2 cycles after the valid done.
- Reset mid-word: assert rst after the 2nd uart_done.
  -> all outputs 0 next cycle, no ack; after release with req=4'b0010 still set, ch1 is regranted and sends 5 bytes.
- Watchdog (macro defined, TIMEOUT=16): withhold uart_done.
  -> error=1 after 16 WAIT cycles, no ack, busy=0, IDLE, and the next requester is granted.
